uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
Parametrised UART receiver, next generation of the team's fixed 8N1 receiver. Configurable data width, parity mode and stop-bit count. Adds an input synchroniser, 3-sample majority voting, parity/framing/break/overrun detection and a valid/ready output handshake. Sits between the serial pin and a byte FIFO or register-bank consumer.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD_RATE, 9600, line rate in bit/s; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division, must be >= 8); HALF_BIT = CLKS_PER_BIT/2
DATA_BITS, 8, data bits per frame, legal range 5..9, sent LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, legal values 1 or 2
SYNC_STAGES, 2, flops in the rx_line synchroniser, minimum 2

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous, active-low reset
rx_line  in  1  asynchronous serial input, idle high
data  out  DATA_BITS  received word, valid while data_valid=1
data_valid  out  1  word available; held until accepted
data_ready  in  1  consumer accepts the word when data_valid & data_ready
rx_busy  out  1  frame reception in progress
parity_err  out  1  parity mismatch, qualified by data_valid
frame_err  out  1  a stop bit was sampled 0, qualified by data_valid
overrun_err  out  1  one-cycle pulse: a frame completed while the previous word was unaccepted
break_det  out  1  one-cycle pulse: break condition detected

Behaviour:
- Reset (reset_n=0 at a clk edge): every output is 0, data=0, FSM goes to IDLE, counters are 0, synchroniser flops and the majority history are 1. Reset has priority in every state, including mid-frame. A partial frame is discarded.
- rx_line passes through SYNC_STAGES flops. All logic uses the synchronised signal rxs. A 3-entry history holds the last three rxs values. sample = majority(history).
- Bit counter width: $clog2(CLKS_PER_BIT). Bit index width: $clog2(DATA_BITS+1).
- IDLE: the start condition is rxs previous=1 and rxs current=0. On it, counter=0, rx_busy=1, go to START.
- START: count to HALF_BIT. At HALF_BIT, if sample=0, counter=0, index=0 and go to DATA. Otherwise this is a false start: go to IDLE and set rx_busy=0.
- DATA: when counter reaches CLKS_PER_BIT-1, shift_reg[index]=sample, index+1, counter=0. After bit DATA_BITS-1, go to PARITY if PARITY!=0, else go to STOP.
- PARITY: sample once at CLKS_PER_BIT-1. The expected bit makes the total count of ones odd (PARITY=1) or even (PARITY=2). A mismatch latches the parity_err candidate.
- STOP: sample at CLKS_PER_BIT-1 for each of the STOP_BITS bits. Any 0 latches the frame_err candidate. The last stop-bit sample completes the frame. The FSM returns to IDLE on the next cycle, mid-stop-bit, so a back-to-back start edge is caught.
- Break: at frame completion, if all data bits, the parity bit (if present) and the first stop bit are 0, pulse break_det. In this case, do not load the word and do not assert data_valid. Go to BRK_WAIT, which holds rx_busy=1 until rxs=1, then go to IDLE.
- Delivery, on the cycle after the final stop sample:
  - If data_valid=0, or data_ready=1 in that same cycle: load data, parity_err and frame_err, set data_valid=1, set rx_busy=0.
  - Otherwise: keep the old word and flags, discard the new frame, pulse overrun_err for one cycle.
- data_valid clears on the cycle after data_valid & data_ready, unless a new word loads in that same cycle. In that case it stays 1 with the new contents. parity_err and frame_err clear together with data_valid.
- When PARITY=0, parity_err stays 0. Unused states are unreachable and recover to IDLE.

Test Plan:
All scenarios use CLK_FREQ=1000000 and BAUD_RATE=100000, so CLKS_PER_BIT=10.
1. 8N1, data_ready=1, send 0xA5 -> data=0xA5 and data_valid=1 for 1 cycle, all error flags 0, rx_busy low after completion. Then send 0x3C back-to-back -> second word 0x3C.
2. PARITY=2, DATA_BITS=7, send 0x37 with parity bit 0 (correct bit is 1) -> data=0x37, parity_err=1. Resend with parity bit 1 -> parity_err=0.
3. 8N1, send 0x55 with stop bit 0 -> data=0x55, frame_err=1. Hold the line low for 12 bit times -> exactly one break_det pulse, no data_valid, rx_busy=1 until the line returns high. The next frame, 0x81, is received cleanly.
4. data_ready=0, send 0x11 then 0x22 -> data stays 0x11, overrun_err pulses once. Assert data_ready -> data_valid drops next cycle. Also check that a completion coinciding with data_ready=1 loads the new word with no overrun.
5. Noise cases:
  - A 3-cycle low glitch in IDLE -> false start, no word, rx_busy back to 0.
  - A 1-cycle inversion at the sample point of bit 3 of 0xF0 -> majority voting yields 0xF0.
6. Pull reset_n low at data bit 4 of a frame -> all outputs 0 on the next edge, no word delivered. Release reset and send 0x9C -> received correctly.

Source files
------------

// File: rtl/uart_rx_param_if.sv
// uart_rx_param_if: word delivery handshake and status flags between receiver and consumer
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data;
    logic                 data_valid;
    logic                 data_ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun_err;
    logic                 break_det;

    modport master (
        output data, data_valid, parity_err, frame_err, overrun_err, break_det,
        input  data_ready
    );

    modport slave (
        input  data, data_valid, parity_err, frame_err, overrun_err, break_det,
        output data_ready
    );
endinterface

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with majority voting, error/break detection and valid/ready output
module uart_rx_param #(
    parameter int CLK_FREQ    = 50000000,
    parameter int BAUD_RATE   = 9600,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic rx_line,
    output logic rx_busy,
    uart_rx_param_if.master rx
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam int IW           = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK_WAIT} state_t;

    state_t               state, next_state;
    logic [SYNC_STAGES-1:0] sync;
    logic [2:0]           hist;
    logic                 rxs, sample;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] shift;
    logic                 sidx, par_bit, stop0, perr_c, ferr_c, done;
    logic                 bit_tick, half_tick, last_data, last_stop, brk_now;

    assign rxs       = sync[SYNC_STAGES-1];
    assign sample    = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
    assign bit_tick  = cnt == CW'(CLKS_PER_BIT - 1);
    assign half_tick = cnt == CW'(HALF_BIT);
    assign last_data = idx == IW'(DATA_BITS - 1);
    assign last_stop = sidx == 1'(STOP_BITS - 1);
    // a break is an all-zero frame up to and including the first stop bit
    assign brk_now   = (shift == '0) && !par_bit && !((STOP_BITS == 1) ? sample : stop0);

    // state register
    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // next-state: falling edge starts a frame, mid-bit sampling walks it through to the stop bits
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     next_state = (hist[0] && !rxs) ? START : IDLE;
            START:    next_state = half_tick ? (sample ? IDLE : DATA) : START;
            DATA:     next_state = (bit_tick && last_data) ? ((PARITY != 0) ? PAR : STOP) : DATA;
            PAR:      next_state = bit_tick ? STOP : PAR;
            STOP:     next_state = (bit_tick && last_stop) ? (brk_now ? BRK_WAIT : IDLE) : STOP;
            BRK_WAIT: next_state = rxs ? IDLE : BRK_WAIT;
            default:  next_state = IDLE;
        endcase
    end

    // busy covers the whole frame, the delivery cycle and the wait for the line to leave break
    always_comb begin
        rx_busy = (state != IDLE) || done;
    end

    // datapath: synchroniser, vote history, counters, shift register, error candidates and delivery
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync           <= '1;
            hist           <= '1;
            cnt            <= '0;
            idx            <= '0;
            shift          <= '0;
            sidx           <= 1'b0;
            par_bit        <= 1'b0;
            stop0          <= 1'b0;
            perr_c         <= 1'b0;
            ferr_c         <= 1'b0;
            done           <= 1'b0;
            rx.data        <= '0;
            rx.data_valid  <= 1'b0;
            rx.parity_err  <= 1'b0;
            rx.frame_err   <= 1'b0;
            rx.overrun_err <= 1'b0;
            rx.break_det   <= 1'b0;
        end else begin
            sync           <= {sync[SYNC_STAGES-2:0], rx_line};
            hist           <= {hist[1:0], rxs};
            cnt            <= (state == START) ? (half_tick ? '0 : cnt + 1'b1)
                            : (state inside {DATA, PAR, STOP}) ? (bit_tick ? '0 : cnt + 1'b1) : '0;
            done           <= 1'b0;
            rx.overrun_err <= 1'b0;
            rx.break_det   <= 1'b0;
            if (state == START) begin
                idx     <= '0;
                sidx    <= 1'b0;
                par_bit <= 1'b0;
                perr_c  <= 1'b0;
                ferr_c  <= 1'b0;
            end
            if (state == DATA && bit_tick) begin
                shift <= {sample, shift[DATA_BITS-1:1]};
                idx   <= idx + 1'b1;
            end
            if (state == PAR && bit_tick) begin
                par_bit <= sample;
                perr_c  <= ((^shift) ^ sample) != (PARITY == 1);
            end
            if (state == STOP && bit_tick) begin
                ferr_c       <= ferr_c | !sample;
                stop0        <= sidx ? stop0 : sample;
                sidx         <= 1'b1;
                done         <= last_stop && !brk_now;
                rx.break_det <= last_stop && brk_now;
            end
            if (done && (!rx.data_valid || rx.data_ready)) begin
                rx.data       <= shift;
                rx.parity_err <= perr_c;
                rx.frame_err  <= ferr_c;
                rx.data_valid <= 1'b1;
            end else if (done) begin
                rx.overrun_err <= 1'b1;
            end else if (rx.data_valid && rx.data_ready) begin
                rx.data_valid <= 1'b0;
                rx.parity_err <= 1'b0;
                rx.frame_err  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: drives serial frames into an 8N1 and a 7E1 receiver and checks delivered words against a frame model
module tb_uart_rx_param;
    logic clk = 1'b0, reset_n = 1'b0, rx_a = 1'b1, rx_b = 1'b1;
    logic busy_a, busy_b;
    int checks = 0, errors = 0;
    int ovr_a = 0, brk_a = 0, vcyc_a = 0;
    logic pva = 1'b0, pra = 1'b0, pvb = 1'b0, prb = 1'b0;
    logic [10:0] qa[$], qb[$], ea[$], eb[$];

    uart_rx_param_if #(.DATA_BITS(8)) ia();
    uart_rx_param_if #(.DATA_BITS(7)) ib();

    uart_rx_param #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(2))
        dut_a (.clk(clk), .reset_n(reset_n), .rx_line(rx_a), .rx_busy(busy_a), .rx(ia));
    uart_rx_param #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .SYNC_STAGES(2))
        dut_b (.clk(clk), .reset_n(reset_n), .rx_line(rx_b), .rx_busy(busy_b), .rx(ib));

    always #5 clk = ~clk;

    // record each newly loaded word and count pulses, sampled on the falling edge
    always @(negedge clk) begin
        if (ia.data_valid === 1'b1 && (!pva || pra)) qa.push_back({1'b0, ia.data, ia.parity_err, ia.frame_err});
        if (ib.data_valid === 1'b1 && (!pvb || prb)) qb.push_back({2'b0, ib.data, ib.parity_err, ib.frame_err});
        ovr_a  <= ovr_a + int'(ia.overrun_err === 1'b1);
        brk_a  <= brk_a + int'(ia.break_det === 1'b1);
        vcyc_a <= vcyc_a + int'(ia.data_valid === 1'b1);
        pva    <= ia.data_valid === 1'b1;
        pra    <= ia.data_ready;
        pvb    <= ib.data_valid === 1'b1;
        prb    <= ib.data_ready;
    end

    function automatic logic [10:0] model(input int d, input int par, input int pbit, input int stopv);
        int   ones = $countones(d) + pbit;
        logic perr = (par != 0) && (((ones % 2) == 1) != (par == 1));
        return {9'(d), perr, stopv == 0};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_line(input int w, input logic v);
        if (w == 0) rx_a = v;
        else        rx_b = v;
    endtask

    task automatic bit_out(input int w, input logic v, input bit g);
        for (int c = 0; c < 10; c++) begin
            set_line(w, (g && c == 5) ? ~v : v);
            tick(1);
        end
    endtask

    task automatic send(input int w, input int d, input int nb, input int par, input int pbit, input int stopv, input int gl);
        bit_out(w, 1'b0, 1'b0);
        for (int i = 0; i < nb; i++) bit_out(w, d[i], i == gl);
        if (par != 0) bit_out(w, pbit[0], 1'b0);
        bit_out(w, stopv[0], 1'b0);
    endtask

    task automatic test_reset;
        ia.data_ready = 1'b0;
        ib.data_ready = 1'b0;
        tick(5);
        checks++;
        if ({busy_a, ia.data_valid, ia.data, ia.parity_err, ia.frame_err, ia.overrun_err, ia.break_det} !== '0) begin
            errors++;
            $display("FAIL reset_a got=%h want=0", {busy_a, ia.data_valid, ia.data, ia.parity_err, ia.frame_err, ia.overrun_err, ia.break_det});
        end
        checks++;
        if ({busy_b, ib.data_valid, ib.data, ib.parity_err, ib.frame_err, ib.overrun_err, ib.break_det} !== '0) begin
            errors++;
            $display("FAIL reset_b got=%h want=0", {busy_b, ib.data_valid, ib.data, ib.parity_err, ib.frame_err, ib.overrun_err, ib.break_det});
        end
        reset_n = 1'b1;
        tick(5);
        checks++;
        if ({busy_a, ia.data_valid} !== 2'b00) begin
            errors++;
            $display("FAIL idle_a got=%b want=00", {busy_a, ia.data_valid});
        end
    endtask

    task automatic test_basic;
        int v0;
        ia.data_ready = 1'b1;
        qa.delete();
        ea.delete();
        v0 = vcyc_a;
        send(0, 'hA5, 8, 0, 0, 1, -1);
        ea.push_back(model('hA5, 0, 0, 1));
        send(0, 'h3C, 8, 0, 0, 1, -1);
        ea.push_back(model('h3C, 0, 0, 1));
        tick(20);
        checks++;
        if (qa.size() != ea.size()) begin
            errors++;
            $display("FAIL basic_count got=%0d want=%0d", qa.size(), ea.size());
        end
        for (int i = 0; i < ea.size() && i < qa.size(); i++) begin
            checks++;
            if (qa[i] !== ea[i]) begin
                errors++;
                $display("FAIL basic_word[%0d] got=%h want=%h", i, qa[i], ea[i]);
            end
        end
        checks++;
        if (vcyc_a - v0 != 2) begin
            errors++;
            $display("FAIL basic_valid_cycles got=%0d want=2", vcyc_a - v0);
        end
        checks++;
        if (busy_a !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy got=%b want=0", busy_a);
        end
    endtask

    task automatic test_parity;
        ib.data_ready = 1'b1;
        qb.delete();
        eb.delete();
        send(1, 'h37, 7, 2, 0, 1, -1);
        eb.push_back(model('h37, 2, 0, 1));
        send(1, 'h37, 7, 2, 1, 1, -1);
        eb.push_back(model('h37, 2, 1, 1));
        tick(20);
        checks++;
        if (qb.size() != eb.size()) begin
            errors++;
            $display("FAIL parity_count got=%0d want=%0d", qb.size(), eb.size());
        end
        for (int i = 0; i < eb.size() && i < qb.size(); i++) begin
            checks++;
            if (qb[i] !== eb[i]) begin
                errors++;
                $display("FAIL parity_word[%0d] got=%h want=%h", i, qb[i], eb[i]);
            end
        end
    endtask

    task automatic test_frame_break;
        int b0;
        ia.data_ready = 1'b1;
        qa.delete();
        b0 = brk_a;
        send(0, 'h55, 8, 0, 0, 0, -1);
        set_line(0, 1'b1);
        tick(20);
        checks++;
        if (qa.size() != 1 || qa[0] !== model('h55, 0, 0, 0)) begin
            errors++;
            $display("FAIL frame_err_word got_count=%0d want=1 word want=%h", qa.size(), model('h55, 0, 0, 0));
        end
        set_line(0, 1'b0);
        tick(115);
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL break_busy got=%b want=1", busy_a);
        end
        set_line(0, 1'b1);
        tick(10);
        checks++;
        if (brk_a - b0 != 1) begin
            errors++;
            $display("FAIL break_pulses got=%0d want=1", brk_a - b0);
        end
        checks++;
        if (busy_a !== 1'b0) begin
            errors++;
            $display("FAIL break_release got=%b want=0", busy_a);
        end
        checks++;
        if (qa.size() != 1) begin
            errors++;
            $display("FAIL break_no_word got=%0d want=1", qa.size());
        end
        send(0, 'h81, 8, 0, 0, 1, -1);
        tick(20);
        checks++;
        if (qa.size() != 2 || qa[qa.size()-1] !== model('h81, 0, 0, 1)) begin
            errors++;
            $display("FAIL after_break got_count=%0d want=2 word want=%h", qa.size(), model('h81, 0, 0, 1));
        end
    endtask

    task automatic test_overrun;
        int o0;
        ia.data_ready = 1'b0;
        tick(2);
        qa.delete();
        o0 = ovr_a;
        send(0, 'h11, 8, 0, 0, 1, -1);
        send(0, 'h22, 8, 0, 0, 1, -1);
        tick(20);
        checks++;
        if (qa.size() != 1 || qa[0] !== model('h11, 0, 0, 1)) begin
            errors++;
            $display("FAIL overrun_words got_count=%0d want=1 word want=%h", qa.size(), model('h11, 0, 0, 1));
        end
        checks++;
        if (ovr_a - o0 != 1) begin
            errors++;
            $display("FAIL overrun_pulses got=%0d want=1", ovr_a - o0);
        end
        checks++;
        if ({ia.data_valid, ia.data} !== 9'h111) begin
            errors++;
            $display("FAIL overrun_hold got=%h want=111", {ia.data_valid, ia.data});
        end
        ia.data_ready = 1'b1;
        tick(1);
        checks++;
        if (ia.data_valid !== 1'b0) begin
            errors++;
            $display("FAIL accept_drop got=%b want=0", ia.data_valid);
        end
        ia.data_ready = 1'b0;
        send(0, 'h33, 8, 0, 0, 1, -1);
        tick(20);
        qa.delete();
        o0 = ovr_a;
        fork
            send(0, 'h44, 8, 0, 0, 1, -1);
            begin
                tick(99);
                ia.data_ready = 1'b1;
                tick(1);
                ia.data_ready = 1'b0;
            end
        join
        tick(20);
        checks++;
        if (qa.size() != 1 || qa[0] !== model('h44, 0, 0, 1)) begin
            errors++;
            $display("FAIL coincide_word got_count=%0d want=1 word want=%h", qa.size(), model('h44, 0, 0, 1));
        end
        checks++;
        if (ovr_a != o0) begin
            errors++;
            $display("FAIL coincide_overrun got=%0d want=0", ovr_a - o0);
        end
        checks++;
        if ({ia.data_valid, ia.data} !== 9'h144) begin
            errors++;
            $display("FAIL coincide_hold got=%h want=144", {ia.data_valid, ia.data});
        end
        ia.data_ready = 1'b1;
        tick(2);
    endtask

    task automatic test_noise;
        qa.delete();
        set_line(0, 1'b0);
        tick(3);
        set_line(0, 1'b1);
        tick(2);
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL glitch_busy got=%b want=1", busy_a);
        end
        tick(10);
        checks++;
        if (busy_a !== 1'b0 || qa.size() != 0) begin
            errors++;
            $display("FAIL false_start busy=%b words=%0d want busy=0 words=0", busy_a, qa.size());
        end
        send(0, 'hF0, 8, 0, 0, 1, 3);
        tick(20);
        checks++;
        if (qa.size() != 1 || qa[0] !== model('hF0, 0, 0, 1)) begin
            errors++;
            $display("FAIL vote_word got_count=%0d want=1 word want=%h", qa.size(), model('hF0, 0, 0, 1));
        end
    endtask

    task automatic test_reset_mid;
        ia.data_ready = 1'b0;
        send(0, 'h12, 8, 0, 0, 1, -1);
        tick(20);
        qa.delete();
        fork
            send(0, 'hF0, 8, 0, 0, 1, -1);
            begin
                tick(52);
                reset_n = 1'b0;
                tick(1);
                checks++;
                if ({busy_a, ia.data_valid, ia.data, ia.parity_err, ia.frame_err, ia.overrun_err, ia.break_det} !== '0) begin
                    errors++;
                    $display("FAIL mid_reset got=%h want=0", {busy_a, ia.data_valid, ia.data, ia.parity_err, ia.frame_err, ia.overrun_err, ia.break_det});
                end
                tick(2);
                reset_n = 1'b1;
            end
        join
        tick(150);
        checks++;
        if (qa.size() != 0 || ia.data_valid !== 1'b0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_discard words=%0d valid=%b busy=%b want 0 0 0", qa.size(), ia.data_valid, busy_a);
        end
        ia.data_ready = 1'b1;
        send(0, 'h9C, 8, 0, 0, 1, -1);
        tick(20);
        checks++;
        if (qa.size() != 1 || qa[0] !== model('h9C, 0, 0, 1)) begin
            errors++;
            $display("FAIL post_reset_word got_count=%0d want=1 word want=%h", qa.size(), model('h9C, 0, 0, 1));
        end
    endtask

    task automatic test_random;
        int d, p;
        ia.data_ready = 1'b1;
        ib.data_ready = 1'b1;
        qa.delete();
        ea.delete();
        qb.delete();
        eb.delete();
        for (int n = 0; n < 6; n++) begin
            d = int'($urandom_range(0, 255));
            send(0, d, 8, 0, 0, 1, -1);
            ea.push_back(model(d, 0, 0, 1));
            tick(int'($urandom_range(0, 12)));
        end
        for (int n = 0; n < 6; n++) begin
            d = int'($urandom_range(0, 127));
            p = int'($urandom_range(0, 1));
            send(1, d, 7, 2, p, 1, -1);
            eb.push_back(model(d, 2, p, 1));
            tick(int'($urandom_range(0, 12)));
        end
        tick(20);
        checks++;
        if (qa.size() != ea.size() || qb.size() != eb.size()) begin
            errors++;
            $display("FAIL rand_count got=%0d/%0d want=%0d/%0d", qa.size(), qb.size(), ea.size(), eb.size());
        end
        for (int i = 0; i < ea.size() && i < qa.size(); i++) begin
            checks++;
            if (qa[i] !== ea[i]) begin
                errors++;
                $display("FAIL rand_a[%0d] got=%h want=%h", i, qa[i], ea[i]);
            end
        end
        for (int i = 0; i < eb.size() && i < qb.size(); i++) begin
            checks++;
            if (qb[i] !== eb[i]) begin
                errors++;
                $display("FAIL rand_b[%0d] got=%h want=%h", i, qb[i], eb[i]);
            end
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset;
        test_basic;
        test_parity;
        test_frame_break;
        test_overrun;
        test_noise;
        test_reset_mid;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
